// File: rtl/pipelined_adder_subtractor.sv
// Pipelined adder/subtractor: the DATA_WIDTH carry chain is cut into STAGES slices with valid/ready flow control.
// Define ADDSUB_SATURATE_EN to add the saturate port and signed clamping of the result.
module pipelined_adder_subtractor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  input  logic [DATA_WIDTH-1:0] data_in_b,
  input  logic                  carry_in,
`ifdef ADDSUB_SATURATE_EN
  input  logic                  saturate,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned SLICE = DATA_WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  logic                  advance;
  logic                  ovf_c;
  logic [DATA_WIDTH-1:0] res_c;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned REM = DATA_WIDTH - k * SLICE;

    // word: finished low slices shifted in from the top, unconsumed A slices at the bottom.
    logic                  vld;
    logic                  md;
    logic                  cy;
`ifdef ADDSUB_SATURATE_EN
    logic                  sat;
`endif
    logic [DATA_WIDTH-1:0] word;
    logic [REM-1:0]        opb;
    logic [SLICE-1:0]      a_s;
    logic [SLICE-1:0]      b_s;
    logic [SLICE:0]        part;
    logic [DATA_WIDTH-1:0] word_nx;

    if (k == 0) begin : g_head
      always_comb begin
        vld  = in_valid;
        md   = mode;
        cy   = mode ^ carry_in;
        word = data_in_a;
        opb  = data_in_b;
`ifdef ADDSUB_SATURATE_EN
        sat  = saturate;
`endif
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
        end else if (advance) begin
          vld <= g_stg[k-1].vld;
        end
      end

      // Skew/deskew payload needs no reset; only the valid bits matter after reset.
      always_ff @(posedge clk) begin
        if (advance) begin
          md   <= g_stg[k-1].md;
          cy   <= g_stg[k-1].part[SLICE];
          word <= g_stg[k-1].word_nx;
          opb  <= g_stg[k-1].opb[REM+SLICE-1:SLICE];
`ifdef ADDSUB_SATURATE_EN
          sat  <= g_stg[k-1].sat;
`endif
        end
      end
    end

    always_comb begin
      a_s     = word[SLICE-1:0];
      b_s     = md ? ~opb[SLICE-1:0] : opb[SLICE-1:0];
      part    = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, cy};
      word_nx = DATA_WIDTH'({part[SLICE-1:0], word} >> SLICE);
    end
  end

  // Overflow from carry into the MSB (recovered from the MSB sum bit) xor carry out.
  always_comb begin
    ovf_c = g_stg[LAST].a_s[SLICE-1] ^ g_stg[LAST].b_s[SLICE-1] ^
            g_stg[LAST].part[SLICE-1] ^ g_stg[LAST].part[SLICE];
    res_c = g_stg[LAST].word_nx;
`ifdef ADDSUB_SATURATE_EN
    if (g_stg[LAST].sat && ovf_c) begin
      res_c = g_stg[LAST].word_nx[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                                : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= g_stg[LAST].vld;
      if (g_stg[LAST].vld) begin
        sum       <= res_c;
        carry_out <= g_stg[LAST].part[SLICE];
        overflow  <= ovf_c;
        zero      <= ~|res_c;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Bench for pipelined_adder_subtractor: three 16-bit instances (STAGES 2, 1, 16) against an arithmetic model.
// Saturation vectors are included when ADDSUB_SATURATE_EN is defined.
module tb_pipelined_adder_subtractor;

  localparam int unsigned DW = 16;
  localparam int unsigned NI = 3;
`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] sum;
    logic          co;
    logic          ov;
    logic          z;
    int            acc_cyc;
    int            stall_mark;
    bit            lit_en;
    logic [DW-1:0] lit_sum;
    logic          lit_co;
    logic          lit_ov;
    logic          lit_z;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] co_o;
  logic [NI-1:0] ov_o;
  logic [NI-1:0] z_o;
  logic [DW-1:0] sum_o [NI];
  logic          mode;
  logic          cin;
  logic          sat;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    stalls = 0;
  int    fired = 0;
  int    cur = 0;
  int    hold = 0;
  bit    accepted;
  beat_t q[$];

  bit            lit_en;
  logic [DW-1:0] lit_sum;
  logic          lit_co;
  logic          lit_ov;
  logic          lit_z;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int unsigned ST = (i == 0) ? 2 : (i == 1) ? 1 : DW;
    pipelined_adder_subtractor #(.DATA_WIDTH(DW), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .mode      (mode),
      .data_in_a (opa),
      .data_in_b (opb),
      .carry_in  (cin),
`ifdef ADDSUB_SATURATE_EN
      .saturate  (sat),
`endif
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .sum       (sum_o[i]),
      .carry_out (co_o[i]),
      .overflow  (ov_o[i]),
      .zero      (z_o[i])
    );
  end

  function automatic int stages_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : int'(DW);
  endfunction

  // Signed/unsigned integer arithmetic view of one beat.
  function automatic beat_t model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                  input logic mm, input logic mc, input logic ms);
    beat_t r;
    int sa, sb, ua, ub, ci, t;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    ci = mc ? 1 : 0;
    if (!mm) begin
      t     = sa + sb + ci;
      r.co  = (ua + ub + ci) > 65535;
      r.sum = DW'(ua + ub + ci);
    end else begin
      t     = sa - sb - ci;
      r.co  = ua >= (ub + ci);
      r.sum = DW'(ua - ub - ci);
    end
    r.ov = (t > 32767) || (t < -32768);
    if (SAT_EN && ms && r.ov) r.sum = (t > 0) ? 16'h7FFF : 16'h8000;
    r.z          = (r.sum == '0);
    r.acc_cyc    = 0;
    r.stall_mark = 0;
    r.lit_en     = 1'b0;
    r.lit_sum    = '0;
    r.lit_co     = 1'b0;
    r.lit_ov     = 1'b0;
    r.lit_z      = 1'b0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h, expected 0x%0h", name, cur, cyc, act, req);
    end
  endtask

  // One clock: compare at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    logic  acc;
    logic  fire;
    beat_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check("rst_out_valid", 32'(out_valid[cur]), 32'd0);
      check("rst_sum", 32'(sum_o[cur]), 32'd0);
      q.delete();
    end else begin
      acc  = in_valid[cur] & in_ready[cur];
      fire = out_valid[cur] & out_ready[cur];
      check("in_ready", 32'(in_ready[cur]), 32'(!out_valid[cur] || out_ready[cur]));
      if (out_valid[cur]) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid[cur]), 32'd0);
        end else begin
          e = q[0];
          check("sum", 32'(sum_o[cur]), 32'(e.sum));
          check("carry_out", 32'(co_o[cur]), 32'(e.co));
          check("overflow", 32'(ov_o[cur]), 32'(e.ov));
          check("zero", 32'(z_o[cur]), 32'(e.z));
          if (fire) begin
            if (e.lit_en) begin
              check("lit_sum", 32'(sum_o[cur]), 32'(e.lit_sum));
              check("lit_carry_out", 32'(co_o[cur]), 32'(e.lit_co));
              check("lit_overflow", 32'(ov_o[cur]), 32'(e.lit_ov));
              check("lit_zero", 32'(z_o[cur]), 32'(e.lit_z));
            end
            if (stalls == e.stall_mark) check("latency", 32'(cyc - e.acc_cyc), 32'(stages_of(cur)));
            fired++;
            void'(q.pop_front());
          end
        end
        if (!out_ready[cur]) stalls++;
      end
      if (acc) begin
        e            = model(opa, opb, mode, cin, sat);
        e.acc_cyc    = cyc;
        e.stall_mark = stalls;
        e.lit_en     = lit_en;
        e.lit_sum    = lit_sum;
        e.lit_co     = lit_co;
        e.lit_ov     = lit_ov;
        e.lit_z      = lit_z;
        q.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (hold > 0) begin
      hold--;
      if (hold == 0) out_ready[cur] = 1'b1;
    end
  endtask

  task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic tm,
                      input logic tc, input logic ts, input bit le, input logic [DW-1:0] ls,
                      input logic lc, input logic lo, input logic lz);
    opa = ta; opb = tb; mode = tm; cin = tc; sat = ts;
    lit_en = le; lit_sum = ls; lit_co = lc; lit_ov = lo; lit_z = lz;
    in_valid[cur] = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 40 && !accepted; n++) step();
    check("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain(input int expect_n);
    in_valid[cur] = 1'b0;
    for (int n = 0; n < 64 && q.size() != 0; n++) step();
    step();
    check("drain_left", 32'(q.size()), 32'd0);
    check("beats_out", 32'(fired), 32'(expect_n));
  endtask

  task automatic vectors();
    fired = 0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 16'h0100, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 1, 16'h0001, 1'b1, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1, 16'h8000, 1'b1, 1'b1, 1'b0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1, 16'h0002, 1'b0, 1'b0, 1'b0);
`else
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1, 16'h8000, 1'b0, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1, 16'h0002, 1'b0, 1'b0, 1'b0);
`endif
    drain(9);
  endtask

  task automatic stream(input int n, input int stall_at);
    fired = 0;
    for (int j = 0; j < n; j++) begin
      if (j == stall_at) begin
        out_ready[cur] = 1'b0;
        hold = 3;
      end
      send(DW'(j * 4099 + 17), DW'(j * 1237 + 3), 1'(j % 2), 1'(j % 3 == 0), 1'(j % 2),
           0, '0, 1'b0, 1'b0, 1'b0);
    end
    drain(n);
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = '0;
    out_ready = '1;
    opa = '0; opb = '0; mode = 1'b0; cin = 1'b0; sat = 1'b0;
    lit_en = 0; lit_sum = '0; lit_co = 1'b0; lit_ov = 1'b0; lit_z = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready[cur]), 32'd1);

    for (int i = 0; i < int'(NI); i++) begin
      cur = i;
      vectors();
      stream(8, 99);
      stream(8, 4);
    end

    // Reset with two beats in flight, one already at the output.
    cur = 0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    in_valid[cur] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid[cur]), 32'd0);
    check("async_rst_sum", 32'(sum_o[cur]), 32'd0);
    q.delete();
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", 32'(in_ready[cur]), 32'd1);
    fired = 0;
    send(16'h0003, 16'h0003, 1'b1, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_subtractor.md
# pipelined_adder_subtractor

Parametrised, pipelined successor to the team's combinational adder/subtractor. Splits the DATA_WIDTH carry chain into STAGES equal slices with one register boundary per slice. The datapath runs at full clock rate for wide operands. Sits between the register-file read ports and the writeback mux in the integer ALU path, with a valid/ready handshake on both sides so it can stall with the rest of the pipeline.

## Interface

Reset is asynchronous and active-low. There is one clock. Ports are listed clock and reset first.

Parameters:
- DATA_WIDTH, 32: operand/result width. Must be a multiple of STAGES.
- STAGES, 2: number of carry-chain slices, which is also the pipeline latency. Legal range is 1..DATA_WIDTH. SLICE = DATA_WIDTH/STAGES.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- mode  in  1  0 = add, 1 = subtract.
- data_in_a  in  DATA_WIDTH  operand A.
- data_in_b  in  DATA_WIDTH  operand B.
- carry_in  in  1  carry (add) or borrow (subtract).
- saturate  in  1  clamp on signed overflow. Present only with ADDSUB_SATURATE_EN.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  DATA_WIDTH  result.
- carry_out  out  1  raw carry out of the MSB.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0 (post-saturation).

## Operation

Arithmetic:
- mode 0: {carry_out, sum} = A + B + carry_in.
- mode 1: computed as A + ~B + (~carry_in). This equals A − B − carry_in.
  - carry_out = 1 means no borrow.
- All arithmetic is modulo 2^DATA_WIDTH.
- overflow = (carry into MSB) XOR carry_out. It is computed in the final stage.

Pipeline structure:
- Stage k (0..STAGES−1) adds slice k of A and of B' (B or ~B) with the carry registered from stage k−1.
  - Stage 0 takes the initial carry (carry_in or ~carry_in).
- Operand slices not yet consumed travel in skew registers.
- Completed low slices travel in deskew registers, so the full result emerges aligned.
- Each stage has a valid bit. mode travels with the beat.

Handshake and flow control:
- Global enable: advance = ~out_valid | out_ready.
- in_ready = advance. A beat is accepted when in_valid & in_ready.
- When advance is high, all stage registers load; bubbles propagate as valid = 0.
- When advance is low, all registers hold.
- Results are never dropped or duplicated. Order is preserved.
- Output registers (sum, carry_out, overflow, zero) change only when advance is high and the last stage holds a valid beat. Otherwise they hold their last values.

## Timing

- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES, given no stall.
- Throughput: one beat per cycle while out_ready = 1.
- STAGES = 1: a single registered stage, latency 1.
- Reset (rst_n = 0, asynchronous): all valid bits, sum, carry_out, overflow and zero clear to 0 immediately. Skew/deskew contents are don't-care.
  - Beats in flight when reset asserts mid-operation are discarded.
  - After rst_n deasserts, in_ready = 1 in the first cycle.
- Simultaneous accept and output: with the pipe full and out_ready = 1, a new beat enters in the same cycle the oldest beat leaves.
- Stall with out_valid = 1 and out_ready = 0:
  - in_ready = 0.
  - Outputs are held stable until the handshake completes.
- in_valid = 0 with out_ready = 1: the pipe drains. out_valid falls after the last beat is consumed.

## Configuration

- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - The saturate port exists and is carried down the pipe with the beat.
  - When saturate = 1 and overflow = 1, sum is clamped. It becomes 0x7F..F if the true result is positive, i.e. the MSB of the wrapped sum is 1. It becomes 0x80..0 otherwise.
  - overflow still reports 1. carry_out is unchanged.
  - zero is evaluated on the clamped value.
- Undefined: no saturate port and pure wrap-around. Area and timing equal the wrap-only datapath.

## Test plan

1. DATA_WIDTH=16, STAGES=2, mode 0, A=0x00FF, B=0x0001, cin=0: 0x0100 appears after 2 cycles, carry_out=0, overflow=0, zero=0. Exercises the cross-slice carry.
2. mode 1, A=0x0000, B=0x0001, cin=0: sum=0xFFFF, carry_out=0 (borrow), overflow=0. Then A=0x8000, B=0x0001, cin=0: sum=0x7FFF, overflow=1.
3. Back-to-back stream of 8 beats with out_ready=1: 8 consecutive out_valid cycles, in order, after a 2-cycle latency. Then hold out_ready=0 for 3 cycles mid-stream: in_ready=0, outputs stable, no loss or duplication.
4. With ADDSUB_SATURATE_EN: add A=0x7FFF, B=0x0001, saturate=1 gives sum=0x7FFF, overflow=1. Subtract A=0x8000, B=0x0001, saturate=1 gives sum=0x8000. With saturate=0, the results are 0x8000 and 0x7FFF.
5. Assert rst_n=0 with 2 beats in flight: out_valid=0 and sum=0 immediately. After release, a fresh beat A=0x0003, B=0x0003, mode 1 yields sum=0, zero=1, carry_out=1.
6. Repeat scenario 3 with STAGES=1 and with STAGES=DATA_WIDTH, and check latency equals STAGES.
